// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised synchronous up/down binary counter with a programmable
// modulus, synchronous clear and parallel load, and wrap or saturate
// behaviour at the count limits. This is the general-purpose counter
// primitive for timers, dividers and address generators.
//
// Parameters:
//   WIDTH    - counter width in bits (>= 1)
//   MODULUS  - count range is 0..MODULUS-1, legal range 2..2**WIDTH
//   SATURATE - 0: wrap at the limits, 1: hold at the limits
//
// Ports:
//   CLK  in   clock, rising-edge active
//   RST  in   asynchronous active-high reset
//   EN   in   count enable
//   UP   in   direction, 1 = increment, 0 = decrement
//   CLR  in   synchronous clear to 0 (highest priority)
//   LOAD in   synchronous parallel load of D (clamped to MODULUS-1)
//   D    in   load value
//   Q    out  current count (registered)
//   TC   out  terminal count, combinational from Q, UP and EN
//   WRAP out  registered one-cycle pulse after a wrap-around edge
//   SAT  out  registered flag after an edge that was pinned at a limit
// ---------------------------------------------------------------------------
module param_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP,
  output logic             SAT
);

  // Largest legal count. When MODULUS equals 2**WIDTH this is all ones,
  // so the wrap path reduces to natural binary rollover.
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             sat_r;

  logic [WIDTH-1:0] q_next_s;
  logic             wrap_next_s;
  logic             sat_next_s;
  logic             at_max_s;
  logic             at_min_s;

  assign at_max_s = (q_r == MAX_Q);
  assign at_min_s = (q_r == ZERO_Q);

  // Terminal count is combinational so it can directly enable a next stage.
  assign TC = EN & ((UP & at_max_s) | (~UP & at_min_s));

  assign Q    = q_r;
  assign WRAP = wrap_r;
  assign SAT  = sat_r;

  // Next-state selection: CLR > LOAD > count > hold; flags default low.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    sat_next_s  = 1'b0;
    if (CLR) begin
      q_next_s = ZERO_Q;
    end else if (LOAD) begin
      // D is only examined here, so an undriven D cannot leak into Q.
      if (D > MAX_Q) begin
        q_next_s = MAX_Q;
      end else begin
        q_next_s = D;
      end
    end else if (EN) begin
      if (UP) begin
        if (!at_max_s) begin
          q_next_s = q_r + ONE_Q;
        end else if (SATURATE) begin
          sat_next_s = 1'b1;
        end else begin
          q_next_s    = ZERO_Q;
          wrap_next_s = 1'b1;
        end
      end else begin
        if (!at_min_s) begin
          q_next_s = q_r - ONE_Q;
        end else if (SATURATE) begin
          sat_next_s = 1'b1;
        end else begin
          q_next_s    = MAX_Q;
          wrap_next_s = 1'b1;
        end
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Count and flag registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r    <= ZERO_Q;
      wrap_r <= 1'b0;
      sat_r  <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
      sat_r  <= sat_next_s;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_param_updown_counter
//
// Three counters (mod 16 wrap, mod 10 wrap, mod 10 saturate) share one set
// of control inputs and are tracked by an arithmetic reference model. A
// separate two-stage mod-10 cascade exercises TC as a cascade enable.
// ---------------------------------------------------------------------------
module tb_param_updown_counter;

  logic       CLK;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [3:0] d;

  logic [3:0] q_a    [3];
  logic       tc_a   [3];
  logic       wrap_a [3];
  logic       sat_a  [3];

  // cascade
  logic       c_en;
  logic       c_clr;
  logic [3:0] c_q1;
  logic [3:0] c_q2;
  logic       c_tc1;
  logic       c_tc2;
  logic       c_wrap1;
  logic       c_wrap2;
  logic       c_sat1;
  logic       c_sat2;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt  [3];
  bit m_wrap [3];
  bit m_sat  [3];

  param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_m16 (
    .CLK(CLK), .RST(rst), .EN(en), .UP(up), .CLR(clr), .LOAD(load), .D(d),
    .Q(q_a[0]), .TC(tc_a[0]), .WRAP(wrap_a[0]), .SAT(sat_a[0]));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_m10 (
    .CLK(CLK), .RST(rst), .EN(en), .UP(up), .CLR(clr), .LOAD(load), .D(d),
    .Q(q_a[1]), .TC(tc_a[1]), .WRAP(wrap_a[1]), .SAT(sat_a[1]));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_m10s (
    .CLK(CLK), .RST(rst), .EN(en), .UP(up), .CLR(clr), .LOAD(load), .D(d),
    .Q(q_a[2]), .TC(tc_a[2]), .WRAP(wrap_a[2]), .SAT(sat_a[2]));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c1 (
    .CLK(CLK), .RST(rst), .EN(c_en), .UP(1'b1), .CLR(c_clr), .LOAD(1'b0),
    .D(4'd0), .Q(c_q1), .TC(c_tc1), .WRAP(c_wrap1), .SAT(c_sat1));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c2 (
    .CLK(CLK), .RST(rst), .EN(c_tc1), .UP(1'b1), .CLR(c_clr), .LOAD(1'b0),
    .D(4'd0), .Q(c_q2), .TC(c_tc2), .WRAP(c_wrap2), .SAT(c_sat2));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int mod_of(input int i);
    return (i == 0) ? 16 : 10;
  endfunction

  function automatic bit sat_of(input int i);
    return (i == 2);
  endfunction

  // One clock edge of the behavioural model for counter i.
  task automatic model_step(input int i);
    int mod;
    int nxt;
    mod = mod_of(i);
    m_wrap[i] = 1'b0;
    m_sat[i]  = 1'b0;
    if (clr) begin
      m_cnt[i] = 0;
    end else if (load) begin
      m_cnt[i] = (int'(d) < mod) ? int'(d) : mod - 1;
    end else if (en) begin
      nxt = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
      if (sat_of(i)) begin
        if (nxt > mod - 1) begin m_sat[i] = 1'b1; nxt = mod - 1; end
        if (nxt < 0)       begin m_sat[i] = 1'b1; nxt = 0;       end
      end else begin
        m_wrap[i] = (nxt >= mod) || (nxt < 0);
        nxt = (nxt + mod) % mod;
      end
      m_cnt[i] = nxt;
    end
  endtask

  function automatic bit model_tc(input int i);
    return en && ((up && m_cnt[i] == mod_of(i) - 1) || (!up && m_cnt[i] == 0));
  endfunction

  // Advance one clock edge, update the model, then step off the edge.
  task automatic tick();
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
      end else begin
        model_step(i);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; d = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; c_en = 1'b0; c_clr = 1'b0;
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
      checks++;
      if (q_a[i] !== 4'd0 || wrap_a[i] !== 1'b0 || sat_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d got Q=%0d WRAP=%b SAT=%b expected 0 0 0",
                 i, q_a[i], wrap_a[i], sat_a[i]);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (q_a[0] !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold got Q=%0d expected 0", q_a[0]);
    end
    rst = 1'b0;
    en = 1'b0;
    tick();
  endtask

  task automatic test_up_wrap16();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      checks++;
      if (tc_a[0] !== (k % 16 == 15)) begin
        errors++;
        $display("FAIL up16_tc step%0d got %b expected %b", k, tc_a[0], (k % 16 == 15));
      end
      tick();
      checks++;
      if (q_a[0] !== 4'((k + 1) % 16) || wrap_a[0] !== (k == 15)) begin
        errors++;
        $display("FAIL up16 step%0d got Q=%0d WRAP=%b expected Q=%0d WRAP=%b",
                 k, q_a[0], wrap_a[0], (k + 1) % 16, (k == 15));
      end
    end
  endtask

  task automatic test_down_wrap10();
    int exp_q [3];
    exp_q = '{9, 8, 7};
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    checks++;
    if (tc_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL down10_tc got %b expected 1", tc_a[1]);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (q_a[1] !== 4'(exp_q[k]) || wrap_a[1] !== (k == 0)) begin
        errors++;
        $display("FAIL down10 step%0d got Q=%0d WRAP=%b expected Q=%0d WRAP=%b",
                 k, q_a[1], wrap_a[1], exp_q[k], (k == 0));
      end
    end
  endtask

  task automatic test_saturate();
    int exp_q [4];
    bit exp_s [4];
    exp_q = '{8, 9, 9, 9};
    exp_s = '{1'b0, 1'b0, 1'b1, 1'b1};
    idle_inputs();
    load = 1'b1; d = 4'd8;
    for (int k = 0; k < 4; k++) begin
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      checks++;
      if (q_a[2] !== 4'(exp_q[k]) || sat_a[2] !== exp_s[k] || wrap_a[2] !== 1'b0) begin
        errors++;
        $display("FAIL saturate step%0d got Q=%0d SAT=%b WRAP=%b expected Q=%0d SAT=%b WRAP=0",
                 k, q_a[2], sat_a[2], wrap_a[2], exp_q[k], exp_s[k]);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (q_a[2] !== 4'd9 || sat_a[2] !== 1'b0) begin
      errors++;
      $display("FAIL sat_release got Q=%0d SAT=%b expected Q=9 SAT=0", q_a[2], sat_a[2]);
    end
  endtask

  task automatic test_load_clamp_clr();
    idle_inputs();
    load = 1'b1; d = 4'd13;
    tick();
    checks++;
    if (q_a[1] !== 4'd9 || q_a[0] !== 4'd13) begin
      errors++;
      $display("FAIL load_clamp got m10=%0d m16=%0d expected 9 13", q_a[1], q_a[0]);
    end
    clr = 1'b1; d = 4'd5;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_a[i] !== 4'd0) begin
        errors++;
        $display("FAIL clr_wins dut%0d got %0d expected 0", i, q_a[i]);
      end
    end
    // Undriven D with LOAD low must not disturb the held count.
    idle_inputs();
    load = 1'b1; d = 4'd4;
    tick();
    load = 1'b0; d = 4'bxxxx;
    tick();
    checks++;
    if (q_a[0] !== 4'd4) begin
      errors++;
      $display("FAIL d_x_hold got %0d expected 4", q_a[0]);
    end
    d = 4'd0;
  endtask

  task automatic test_async_reset();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    repeat (6) tick();
    checks++;
    if (q_a[0] !== 4'd6) begin
      errors++;
      $display("FAIL pre_reset got %0d expected 6", q_a[0]);
    end
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
      checks++;
      if (q_a[i] !== 4'd0 || wrap_a[i] !== 1'b0 || sat_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d got Q=%0d WRAP=%b SAT=%b expected 0 0 0",
                 i, q_a[i], wrap_a[i], sat_a[i]);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (q_a[0] !== 4'd1) begin
      errors++;
      $display("FAIL resume got %0d expected 1", q_a[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) != 0;
      clr  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 9) == 0);
      d    = 4'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tc_a[i] !== model_tc(i)) begin
          errors++;
          $display("FAIL rand_tc n%0d dut%0d got %b expected %b", n, i, tc_a[i], model_tc(i));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_a[i] !== 4'(m_cnt[i]) || wrap_a[i] !== m_wrap[i] || sat_a[i] !== m_sat[i]) begin
          errors++;
          $display("FAIL rand n%0d dut%0d got Q=%0d WRAP=%b SAT=%b expected Q=%0d WRAP=%b SAT=%b",
                   n, i, q_a[i], wrap_a[i], sat_a[i], m_cnt[i], m_wrap[i], m_sat[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_cascade();
    int wraps;
    int value;
    wraps = 0;
    c_clr = 1'b1;
    tick();
    c_clr = 1'b0; c_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      value = 10 * int'(c_q2) + int'(c_q1);
      if (c_wrap2 === 1'b1) wraps++;
      checks++;
      if (value != (k + 1) % 100 || c_wrap2 !== (k == 99)) begin
        errors++;
        $display("FAIL cascade step%0d got %0d WRAP2=%b expected %0d WRAP2=%b",
                 k, value, c_wrap2, (k + 1) % 100, (k == 99));
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL cascade_wraps got %0d expected 1", wraps);
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap16();
    test_down_wrap10();
    test_saturate();
    test_load_clamp_clr();
    test_async_reset();
    test_random();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised synchronous binary counter; successor to the fixed 4-bit up-only T-flip-flop counter.
- Adds configurable width and modulus, up/down direction, synchronous clear and parallel load, wrap or saturate mode, and terminal-count/wrap flags.
- Serves as the general-purpose counter primitive for timers, dividers and address generators in the design.

Parameters:
- WIDTH, 4, counter width in bits (≥1).
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2^WIDTH. Default gives the legacy 4-bit binary sequence.
- SATURATE, 0. 0 = wrap at limits; 1 = hold at limits.

Ports:
- CLK  in  1  clock, rising-edge active.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  count enable.
- UP  in  1  direction. 1 = increment, 0 = decrement.
- CLR  in  1  synchronous clear to 0.
- LOAD  in  1  synchronous parallel load.
- D  in  WIDTH  load value.
- Q  out  WIDTH  current count (registered).
- TC  out  1  terminal count (combinational from Q, UP, EN).
- WRAP  out  1  registered one-cycle wrap pulse.
- SAT  out  1  registered saturation-hit flag.

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-high.
- Reset:
  - RST high forces Q=0, WRAP=0, SAT=0 immediately, independent of CLK.
  - Deassertion is released at the next CLK edge.
  - Reset mid-count discards all state; no partial update.
- Per-edge priority, highest first: CLR > LOAD > EN count > hold.
  - CLR=1: Q<=0, WRAP<=0, SAT<=0.
  - LOAD=1 (CLR=0): Q<=D if D<MODULUS, else Q<=MODULUS-1 (clamp). WRAP<=0, SAT<=0.
  - EN=1, UP=1:
    - Q<MODULUS-1: Q<=Q+1.
    - Q=MODULUS-1, SATURATE=0: Q<=0, WRAP<=1.
    - Q=MODULUS-1, SATURATE=1: Q held, SAT<=1.
  - EN=1, UP=0:
    - Q>0: Q<=Q-1.
    - Q=0, SATURATE=0: Q<=MODULUS-1, WRAP<=1.
    - Q=0, SATURATE=1: Q held, SAT<=1.
  - EN=0: Q held.
- Flag timing:
  - WRAP and SAT are 1 only for the cycle following the event edge; cleared on any edge without the event.
  - SAT re-asserts every cycle while pinned at a limit with EN=1 in the same direction.
- TC = EN & ((UP & Q==MODULUS-1) | (~UP & Q==0)). Combinational, zero latency; usable as cascade enable for the next stage.
- Direction change: takes effect on the next edge; no dead cycle.
- Arithmetic:
  - Internal compare uses WIDTH bits.
  - MODULUS=2^WIDTH reduces to natural binary rollover.
  - Q never holds a value ≥MODULUS.
- Latency: Q updates one edge after the control inputs are sampled.
- No X propagation from D when LOAD=0.

Test Plan:
- WIDTH=4, MODULUS=16, EN=1, UP=1 from reset, 17 edges -> Q steps 0..15 then 0; TC=1 while Q=15; WRAP=1 in the cycle after Q returns to 0.
- WIDTH=4, MODULUS=10, UP=0 from Q=0, 3 edges -> Q=9,8,7; WRAP pulses once after the first edge.
- SATURATE=1, MODULUS=10, LOAD D=8, then UP=1 for 4 edges -> Q=8,9,9,9; SAT=1 on the 3rd and 4th cycles; WRAP stays 0.
- MODULUS=10, LOAD D=13 -> Q=9. Same edge with CLR=1 and LOAD=1, D=5 -> Q=0 (CLR wins).
- Assert RST asynchronously mid-count at Q=6, between edges -> Q=0, WRAP=0, SAT=0 before the next edge; counting resumes from 0 at the first edge after RST falls.
- Cascade: stage1 TC drives stage2 EN, both WIDTH=4, MODULUS=10, 100 edges -> combined BCD value wraps 99->00; stage2 WRAP pulses exactly once.
